me_stage: RTL and testbench
===========================

# me_stage

Memory-access pipeline stage of the five-stage LoongArch core. It sits between EX and WB and latches the EX-to-ME bus under the valid/allow-in handshake. It captures the synchronous data-SRAM read response and holds it in a one-entry buffer while WB stalls. It produces the final writeback value (ALU result or aligned load data) and reports its destination register to ID for hazard detection.

## Interface
Parameters:
- `EM_W`, 71 (74 with `ME_LOAD_EXT_EN`): width of `EX_to_ME_Bus`.
- `MW_W`, 70: width of `ME_to_WB_Bus`.

Ports:
- `clk`  in  1  core clock; sole clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `EX_to_ME_Valid`  in  1  EX holds a valid instruction for ME.
- `ME_Allow_in`  out  1  ME accepts a new instruction this cycle.
- `EX_to_ME_Bus`  in  EM_W  fields, MSB first:
  - pc[31:0]
  - res_from_mem
  - gr_we
  - dest[4:0]
  - alu_result[31:0]
  - ld_op[2:0], lowest 3 bits, present only with the macro
- `data_sram_rdata`  in  32  read data for the request EX issued in the handoff cycle.
- `ME_to_WB_Valid`  out  1  ME presents a valid instruction to WB.
- `WB_Allow_in`  in  1  WB accepts this cycle.
- `ME_to_WB_Bus`  out  MW_W  fields, MSB first:
  - pc[31:0]
  - gr_we
  - dest[4:0]
  - final_result[31:0]
- `ME_dest`  out  5  dest when ME_valid and gr_we, else 5'd0.

## Operation
- State: `ME_valid`, bus register `me_bus`, `rdata_buf[31:0]`, `buf_valid`.
- `ME_ready_go` = 1. No multi-cycle operations in this stage.
- `ME_Allow_in` = !ME_valid || (ME_ready_go && WB_Allow_in).
- `ME_to_WB_Valid` = ME_valid && ME_ready_go.
- Accept: when `ME_Allow_in` is high, `ME_valid` <= `EX_to_ME_Valid`. `me_bus` loads only when `EX_to_ME_Valid && ME_Allow_in`.
- Response buffer:
  - Capture: in a cycle with ME_valid && !buf_valid && !WB_Allow_in, set rdata_buf <= data_sram_rdata and buf_valid <= 1.
  - Clear: buf_valid <= 0 whenever the instruction leaves (ME_to_WB_Valid && WB_Allow_in).
  - Accept and leave in the same cycle: the leave clears the buffer and the new instruction starts with buf_valid = 0.
- Load data source: `mem_word` = buf_valid ? rdata_buf : data_sram_rdata.
- `final_result` = res_from_mem ? load_data : alu_result.
- Non-load instructions ignore the buffer. Capturing garbage for them is harmless.
- Load alignment uses addr = alu_result[1:0], with ld_op encodings:
  - 000 `ld.w`: whole word.
  - 001 `ld.b`: byte at addr, sign-extended.
  - 010 `ld.bu`: byte at addr, zero-extended.
  - 011 `ld.h`: halfword at addr[1], sign-extended.
  - 100 `ld.hu`: halfword at addr[1], zero-extended.
  - 101–111: treated as 000.
- Misaligned addresses are not checked; the low address bits select lanes as above.

## Timing
- Latency: one cycle from EX handoff to `ME_to_WB_Valid`, with no stall.
- `data_sram_rdata` is sampled only in the first residency cycle, live or captured. Later cycles use `rdata_buf`.
- Reset values: `ME_valid`=0, `buf_valid`=0, `me_bus`=0.
  - Outputs after reset: `ME_Allow_in`=1, `ME_to_WB_Valid`=0, `ME_dest`=0, `ME_to_WB_Bus`=0.
- Reset mid-stall: the held instruction and its buffered data are discarded and no output appears afterwards.
- Back-to-back: a full pipeline with WB_Allow_in=1 sustains one instruction per cycle.
- Stall: a WB stall of N cycles holds `ME_to_WB_Bus` stable for N+1 cycles, even if `data_sram_rdata` changes.

## Configuration
- `ME_LOAD_EXT_EN` defined:
  - EM_W=74.
  - `ld_op` is decoded and byte/halfword loads are supported.
- Not defined:
  - EM_W=71 and there is no `ld_op` field.
  - Every load returns the full `mem_word`.

## Structure
- Package `me_pkg` holds:
  - the EM_W/MW_W constants,
  - bus field offsets,
  - the `ld_op` encodings (`LD_W`, `LD_B`, `LD_BU`, `LD_H`, `LD_HU`).
- EX and WB import the same package.
- Sub-module `me_load_align`: combinational. Inputs are mem_word, addr[1:0] and ld_op; output is load_data. Instantiated only under `ME_LOAD_EXT_EN`.

## Test plan
- Non-load passthrough: EX sends pc=0x1c000000, alu_result=0x12345678, dest=5, gr_we=1, res_from_mem=0. Next cycle: ME_to_WB_Valid=1, final_result=0x12345678, ME_dest=5.
- `ld.w` with WB stalled 3 cycles: rdata=0xDEADBEEF in the first residency cycle, then rdata=0x0 for the remaining cycles. final_result stays 0xDEADBEEF for 4 cycles and ME_Allow_in=0 throughout.
- Byte and halfword loads (macro on), rdata=0x80FF7F01:
  - `ld.b` addr=3 → 0xFFFFFF80.
  - `ld.bu` addr=3 → 0x00000080.
  - `ld.h` addr=2 → 0xFFFF80FF.
  - `ld.hu` addr=0 → 0x00007F01.
- Back-to-back: three instructions on consecutive cycles with WB_Allow_in=1. Three consecutive ME_to_WB_Valid pulses in order, and buf_valid never set.
- Reset mid-stall: a load is held with buf_valid=1 and reset asserts. Next cycle: ME_to_WB_Valid=0, ME_dest=0, ME_Allow_in=1, and nothing is emitted after reset deasserts.
- Hazard reporting: an instruction with gr_we=0 and dest=7 gives ME_dest=0. An invalid slot gives ME_dest=0.

Source files
------------

// File: rtl/me_pkg.sv
// Shared EX->ME and ME->WB bus layout and load-op encodings for the LoongArch pipeline.
// Latency: none (constants only).
// Backpressure: none. ME_LOAD_EXT_EN adds a 3-bit ld_op field at the bottom of EX_to_ME_Bus.
package me_pkg;

`ifdef ME_LOAD_EXT_EN
    localparam int EM_W = 74;
`else
    localparam int EM_W = 71;
`endif
    localparam int MW_W = 70;

    // EX_to_ME_Bus, MSB first: pc, res_from_mem, gr_we, dest, alu_result, [ld_op]
    localparam int EM_LDOP_LSB = 0;
    localparam int EM_ALU_LSB  = EM_W - 71;
    localparam int EM_DEST_LSB = EM_ALU_LSB + 32;
    localparam int EM_GRWE_BIT = EM_ALU_LSB + 37;
    localparam int EM_RFM_BIT  = EM_ALU_LSB + 38;
    localparam int EM_PC_LSB   = EM_ALU_LSB + 39;

    // ME_to_WB_Bus, MSB first: pc, gr_we, dest, final_result
    localparam int MW_RES_LSB  = 0;
    localparam int MW_DEST_LSB = 32;
    localparam int MW_GRWE_BIT = 37;
    localparam int MW_PC_LSB   = 38;

    // ld_op encodings; 101..111 behave as LD_W
    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_BU = 3'b010;
    localparam logic [2:0] LD_H  = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

endpackage

// File: rtl/me_load_align.sv
// Selects and extends the byte/halfword lane of a loaded word (only built with ME_LOAD_EXT_EN).
// Latency: combinational.
// Backpressure: none; pure datapath.
module me_load_align
    import me_pkg::*;
(
    input  logic [31:0] mem_word,
    input  logic [1:0]  addr,
    input  logic [2:0]  ld_op,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Lane selection by the low address bits; misaligned addresses are not trapped here
    always_comb begin
        byte_lane = mem_word[7:0];
        case (addr)
            2'd0:    byte_lane = mem_word[7:0];
            2'd1:    byte_lane = mem_word[15:8];
            2'd2:    byte_lane = mem_word[23:16];
            default: byte_lane = mem_word[31:24];
        endcase
        half_lane = addr[1] ? mem_word[31:16] : mem_word[15:0];
    end

    // Extension per load type; unused encodings fall back to the full word
    always_comb begin
        load_data = mem_word;
        case (ld_op)
            LD_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
            LD_BU:   load_data = {24'd0, byte_lane};
            LD_H:    load_data = {{16{half_lane[15]}}, half_lane};
            LD_HU:   load_data = {16'd0, half_lane};
            default: load_data = mem_word;
        endcase
    end

endmodule

// File: rtl/me_stage.sv
// Memory-access stage: latches EX->ME bus, buffers the SRAM read response across WB stalls, builds writeback value.
// Latency: one cycle from EX handoff to ME_to_WB_Valid when WB is not stalling.
// Backpressure: ME_Allow_in drops while holding an instruction WB refuses; ME_LOAD_EXT_EN enables byte/halfword loads.
module me_stage
    import me_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             EX_to_ME_Valid,
    output logic             ME_Allow_in,
    input  logic [EM_W-1:0]  EX_to_ME_Bus,
    input  logic [31:0]      data_sram_rdata,
    output logic             ME_to_WB_Valid,
    input  logic             WB_Allow_in,
    output logic [MW_W-1:0]  ME_to_WB_Bus,
    output logic [4:0]       ME_dest
);

    logic            me_valid;
    logic            me_ready_go;
    logic [EM_W-1:0] me_bus;
    logic [31:0]     rdata_buf;
    logic            buf_valid;
    logic            leave;

    logic [31:0] pc;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] mem_word;
    logic [31:0] load_data;
    logic [31:0] final_result;

    assign me_ready_go    = 1'b1;
    assign ME_Allow_in    = !me_valid || (me_ready_go && WB_Allow_in);
    assign ME_to_WB_Valid = me_valid && me_ready_go;
    assign leave          = ME_to_WB_Valid && WB_Allow_in;

    // Valid bit follows EX whenever this stage can take a new instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            me_valid <= 1'b0;
        end else if (ME_Allow_in) begin
            me_valid <= EX_to_ME_Valid;
        end
    end

    // Bus register loads only on a real handoff so a held instruction stays intact
    always_ff @(posedge clk) begin
        if (reset) begin
            me_bus <= '0;
        end else if (EX_to_ME_Valid && ME_Allow_in) begin
            me_bus <= EX_to_ME_Bus;
        end
    end

    // The SRAM response is only valid in the first residency cycle; keep it while WB stalls.
    // Leaving always clears, so a same-cycle newcomer starts reading live data.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid <= 1'b0;
            rdata_buf <= 32'd0;
        end else if (leave) begin
            buf_valid <= 1'b0;
        end else if (me_valid && !buf_valid && !WB_Allow_in) begin
            buf_valid <= 1'b1;
            rdata_buf <= data_sram_rdata;
        end
    end

    assign pc           = me_bus[EM_PC_LSB +: 32];
    assign res_from_mem = me_bus[EM_RFM_BIT];
    assign gr_we        = me_bus[EM_GRWE_BIT];
    assign dest         = me_bus[EM_DEST_LSB +: 5];
    assign alu_result   = me_bus[EM_ALU_LSB +: 32];

    assign mem_word = buf_valid ? rdata_buf : data_sram_rdata;

`ifdef ME_LOAD_EXT_EN
    logic [2:0] ld_op;
    assign ld_op = me_bus[EM_LDOP_LSB +: 3];

    me_load_align u_load_align (
        .mem_word  (mem_word),
        .addr      (alu_result[1:0]),
        .ld_op     (ld_op),
        .load_data (load_data)
    );
`else
    assign load_data = mem_word;
`endif

    assign final_result = res_from_mem ? load_data : alu_result;

    assign ME_to_WB_Bus = {pc, gr_we, dest, final_result};
    assign ME_dest      = (me_valid && gr_we) ? dest : 5'd0;

endmodule

// File: tb/tb_me_stage.sv
// Directed bench for me_stage: passthrough, stalled loads, lane alignment, back-to-back, reset mid-stall, hazard dest.
// Latency: expects one-cycle EX->WB handoff.
// Backpressure: drives WB_Allow_in low to exercise the response buffer.
module tb_me_stage;
    import me_pkg::*;

    logic            clk;
    logic            reset;
    logic            ex_valid;
    logic            me_allow_in;
    logic [EM_W-1:0] ex_bus;
    logic [31:0]     rdata;
    logic            wb_valid;
    logic            wb_allow_in;
    logic [MW_W-1:0] wb_bus;
    logic [4:0]      me_dest;

    int checks = 0;
    int errors = 0;

    me_stage dut (
        .clk             (clk),
        .reset           (reset),
        .EX_to_ME_Valid  (ex_valid),
        .ME_Allow_in     (me_allow_in),
        .EX_to_ME_Bus    (ex_bus),
        .data_sram_rdata (rdata),
        .ME_to_WB_Valid  (wb_valid),
        .WB_Allow_in     (wb_allow_in),
        .ME_to_WB_Bus    (wb_bus),
        .ME_dest         (me_dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [69:0] got, input logic [69:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // drive point: just after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // sample point: falling edge
    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [70:0] em_base(input logic [31:0] pc, input logic rfm, input logic we,
                                            input logic [4:0] dest, input logic [31:0] alu);
        return {pc, rfm, we, dest, alu};
    endfunction

    function automatic logic [EM_W-1:0] to_em(input logic [70:0] base);
`ifdef ME_LOAD_EXT_EN
        return {base, 3'b000};
`else
        return base;
`endif
    endfunction

    function automatic logic [69:0] wb_exp(input logic [31:0] pc, input logic we,
                                           input logic [4:0] dest, input logic [31:0] res);
        return {pc, we, dest, res};
    endfunction

    logic [31:0] b2b_alu [3];
    logic [31:0] b2b_rd  [3];

    initial begin
        reset       = 1'b1;
        ex_valid    = 1'b0;
        ex_bus      = '0;
        rdata       = 32'd0;
        wb_allow_in = 1'b1;

        // ---------------- reset state
        step();
        step();
        mid();
        check("rst_allow_in", 70'(me_allow_in), 70'd1);
        check("rst_wb_valid", 70'(wb_valid), 70'd0);
        check("rst_me_dest", 70'(me_dest), 70'd0);
        check("rst_wb_bus", 70'(wb_bus), 70'd0);
        step();
        reset = 1'b0;

        // ---------------- non-load passthrough
        ex_valid = 1'b1;
        ex_bus   = to_em(em_base(32'h1c000000, 1'b0, 1'b1, 5'd5, 32'h12345678));
        mid();
        check("pass_allow_in", 70'(me_allow_in), 70'd1);
        step();
        ex_valid = 1'b0;
        rdata    = 32'hA5A5A5A5;
        mid();
        check("pass_valid", 70'(wb_valid), 70'd1);
        check("pass_bus", 70'(wb_bus), wb_exp(32'h1c000000, 1'b1, 5'd5, 32'h12345678));
        check("pass_dest", 70'(me_dest), 70'd5);
        step();
        mid();
        check("idle_valid", 70'(wb_valid), 70'd0);
        check("idle_dest", 70'(me_dest), 70'd0);

        // ---------------- ld.w held across a 3-cycle WB stall
        ex_valid    = 1'b1;
        ex_bus      = to_em(em_base(32'h1c000004, 1'b1, 1'b1, 5'd3, 32'h00000100));
        wb_allow_in = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            ex_valid    = 1'b0;
            rdata       = (c == 1) ? 32'hDEADBEEF : 32'h00000000;
            wb_allow_in = (c == 4);
            mid();
            check($sformatf("stall_valid_c%0d", c), 70'(wb_valid), 70'd1);
            check($sformatf("stall_bus_c%0d", c), 70'(wb_bus),
                  wb_exp(32'h1c000004, 1'b1, 5'd3, 32'hDEADBEEF));
            if (c < 4) check($sformatf("stall_allow_c%0d", c), 70'(me_allow_in), 70'd0);
        end
        step();
        mid();
        check("stall_drained", 70'(wb_valid), 70'd0);

        // ---------------- byte / halfword lanes, issued back to back
        begin
            logic [2:0]  ops [7];
            logic [1:0]  adr [7];
            logic [31:0] exp_res [7];
`ifdef ME_LOAD_EXT_EN
            ops = '{LD_B, LD_BU, LD_H, LD_HU, LD_B, LD_BU, 3'b101};
            adr = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd2, 2'd1};
            exp_res = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01,
                        32'h0000007F, 32'h000000FF, 32'h80FF7F01};
`else
            ops = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
            adr = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd1, 2'd2, 2'd1};
            exp_res = '{32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01,
                        32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01};
`endif
            rdata       = 32'h80FF7F01;
            wb_allow_in = 1'b1;
            for (int i = 0; i <= 7; i++) begin
                if (i < 7) begin
                    ex_valid = 1'b1;
`ifdef ME_LOAD_EXT_EN
                    ex_bus = {em_base(32'h1c000100 + 32'(i * 4), 1'b1, 1'b1, 5'd9,
                                      {30'h0, adr[i]}), ops[i]};
`else
                    ex_bus = to_em(em_base(32'h1c000100 + 32'(i * 4), 1'b1, 1'b1, 5'd9,
                                           {28'h0, ops[i][1:0], adr[i]}));
`endif
                end else begin
                    ex_valid = 1'b0;
                end
                if (i > 0) begin
                    mid();
                    check($sformatf("lane_%0d", i - 1), 70'(wb_bus[31:0]), 70'(exp_res[i - 1]));
                end
                step();
            end
        end

        // ---------------- back-to-back: alu, load, alu with rdata changing every cycle
        b2b_alu = '{32'h11111111, 32'h00000200, 32'h33333333};
        b2b_rd  = '{32'h0BAD0BAD, 32'hCAFEF00D, 32'h0F0F0F0F};
        wb_allow_in = 1'b1;
        for (int i = 0; i <= 3; i++) begin
            if (i < 3) begin
                ex_valid = 1'b1;
                ex_bus   = to_em(em_base(32'h1c000200 + 32'(i * 4), (i == 1), 1'b1,
                                         5'(i + 1), b2b_alu[i]));
            end else begin
                ex_valid = 1'b0;
            end
            if (i > 0) rdata = b2b_rd[i - 1];
            if (i > 0) begin
                mid();
                check($sformatf("b2b_valid_%0d", i - 1), 70'(wb_valid), 70'd1);
                check($sformatf("b2b_bus_%0d", i - 1), 70'(wb_bus),
                      wb_exp(32'h1c000200 + 32'((i - 1) * 4), 1'b1, 5'(i),
                             (i == 2) ? 32'hCAFEF00D : b2b_alu[i - 1]));
                check($sformatf("b2b_allow_%0d", i - 1), 70'(me_allow_in), 70'd1);
                check($sformatf("b2b_buf_%0d", i - 1), 70'(dut.buf_valid), 70'd0);
            end
            step();
        end
        mid();
        check("b2b_drained", 70'(wb_valid), 70'd0);

        // ---------------- hazard reporting with gr_we=0
        step();
        ex_valid = 1'b1;
        ex_bus   = to_em(em_base(32'h1c000300, 1'b0, 1'b0, 5'd7, 32'h00000007));
        step();
        ex_valid = 1'b0;
        mid();
        check("nowe_valid", 70'(wb_valid), 70'd1);
        check("nowe_dest", 70'(me_dest), 70'd0);
        check("nowe_bus", 70'(wb_bus), wb_exp(32'h1c000300, 1'b0, 5'd7, 32'h00000007));

        // ---------------- reset while a buffered load is stalled
        step();
        ex_valid    = 1'b1;
        ex_bus      = to_em(em_base(32'h1c000400, 1'b1, 1'b1, 5'd12, 32'h00000040));
        wb_allow_in = 1'b0;
        step();
        ex_valid = 1'b0;
        rdata    = 32'h11112222;
        mid();
        check("rs_dest_before", 70'(me_dest), 70'd12);
        step();
        rdata = 32'h0;
        mid();
        check("rs_buf_set", 70'(dut.buf_valid), 70'd1);
        check("rs_held_result", 70'(wb_bus[31:0]), 70'h11112222);
        step();
        reset = 1'b1;
        step();
        mid();
        check("rs_valid", 70'(wb_valid), 70'd0);
        check("rs_dest", 70'(me_dest), 70'd0);
        check("rs_allow_in", 70'(me_allow_in), 70'd1);
        check("rs_buf_clear", 70'(dut.buf_valid), 70'd0);
        step();
        reset       = 1'b0;
        wb_allow_in = 1'b1;
        for (int c = 0; c < 5; c++) begin
            mid();
            check($sformatf("rs_quiet_%0d", c), 70'(wb_valid), 70'd0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
